// File: rtl/clarvi_load_assembler.sv
// Load assembler: gathers four memory halfwords, aligns and extends them, emits four result parts.
// Optional LOAD_EARLY_EMIT_EN: byte and aligned halfword loads emit right after part 0.
module clarvi_load_assembler (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        main_read_pending,
    input  logic [1:0]  read_part,
    input  logic        word_offset,
    input  logic [1:0]  memory_width,
    input  logic        memory_read_unsigned,
    input  logic [15:0] main_read_data,
    output logic        load_valid,
    output logic [1:0]  load_part,
    output logic [15:0] load_data,
    output logic        load_busy,
    output logic        load_protocol_error
);

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_EMIT} state_t;

    localparam logic [1:0] W_B = 2'd0;
    localparam logic [1:0] W_H = 2'd1;
    localparam logic [1:0] W_W = 2'd2;
    localparam logic [1:0] W_D = 2'd3;

    state_t      r_state, w_state_n;
    logic [1:0]  r_expect, w_expect_n;
    logic [1:0]  r_idx, w_idx_n;
    logic [63:0] r_buf, w_buf_n;
    logic [1:0]  r_width, w_width_n;
    logic        r_off, w_off_n;
    logic        r_uns, w_uns_n;
    logic        r_early, w_early_n;
    logic        r_err, w_err_n;
    logic        r_valid, w_valid_n;
    logic [1:0]  r_part, w_part_n;
    logic [15:0] r_data, w_data_n;
    logic        r_busy, w_busy_n;

    logic        w_early_ok;
    logic        w_match;
    logic [63:0] w_raw;
    logic [63:0] w_result;

`ifdef LOAD_EARLY_EMIT_EN
    assign w_early_ok = (memory_width == W_B) ||
                        ((memory_width == W_H) && !word_offset);
`else
    assign w_early_ok = 1'b0;
`endif

    assign w_match = main_read_pending && (read_part == r_expect);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_expect <= 2'd0;
            r_idx    <= 2'd0;
            r_buf    <= 64'd0;
            r_width  <= 2'd0;
            r_off    <= 1'b0;
            r_uns    <= 1'b0;
            r_early  <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
            r_part   <= 2'd0;
            r_data   <= 16'd0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_expect <= w_expect_n;
            r_idx    <= w_idx_n;
            r_buf    <= w_buf_n;
            r_width  <= w_width_n;
            r_off    <= w_off_n;
            r_uns    <= w_uns_n;
            r_early  <= w_early_n;
            r_err    <= w_err_n;
            r_valid  <= w_valid_n;
            r_part   <= w_part_n;
            r_data   <= w_data_n;
            r_busy   <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_expect_n = r_expect;
        w_idx_n    = r_idx;
        w_buf_n    = r_buf;
        w_width_n  = r_width;
        w_off_n    = r_off;
        w_uns_n    = r_uns;
        w_early_n  = r_early;
        w_err_n    = r_err;
        unique case (r_state)
            ST_IDLE: begin
                if (main_read_pending) begin
                    if (r_expect == 2'd0 && read_part == 2'd0) begin
                        w_buf_n    = {48'd0, main_read_data};
                        w_width_n  = memory_width;
                        w_off_n    = word_offset;
                        w_uns_n    = memory_read_unsigned;
                        w_early_n  = w_early_ok;
                        w_expect_n = 2'd1;
                        w_idx_n    = 2'd0;
                        w_state_n  = w_early_ok ? ST_EMIT : ST_COLLECT;
                    end else if (r_expect != 2'd0 && w_match) begin
                        // trailing parts of an early-emitted load
                        w_expect_n = r_expect + 2'd1;
                    end else begin
                        w_err_n    = 1'b1;
                        w_buf_n    = 64'd0;
                        w_expect_n = 2'd0;
                    end
                end
            end
            ST_COLLECT: begin
                if (main_read_pending) begin
                    if (w_match) begin
                        w_buf_n[{r_expect, 4'b0000} +: 16] = main_read_data;
                        w_expect_n = r_expect + 2'd1;
                        if (r_expect == 2'd3) begin
                            w_state_n = ST_EMIT;
                            w_idx_n   = 2'd0;
                        end
                    end else begin
                        w_err_n    = 1'b1;
                        w_buf_n    = 64'd0;
                        w_expect_n = 2'd0;
                        w_state_n  = ST_IDLE;
                    end
                end
            end
            ST_EMIT: begin
                if (!stall) begin
                    if (r_idx == 2'd3) w_state_n = ST_IDLE;
                    else w_idx_n = r_idx + 2'd1;
                end
                if (main_read_pending) begin
                    if (r_early && w_match && r_expect != 2'd0) begin
                        w_expect_n = r_expect + 2'd1;
                    end else begin
                        w_err_n    = 1'b1;
                        w_buf_n    = 64'd0;
                        w_expect_n = 2'd0;
                        w_state_n  = ST_IDLE;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (flush) begin
            w_state_n  = ST_IDLE;
            w_buf_n    = 64'd0;
            w_expect_n = 2'd0;
            w_err_n    = r_err;
        end
    end

    // result is formed from the next buffer so part 0 leaves on the capture edge
    always_comb begin
        w_raw    = w_buf_n >> {w_off_n, 3'b000};
        w_result = w_raw;
        unique case (w_width_n)
            W_B: w_result = {{56{~w_uns_n & w_raw[7]}},  w_raw[7:0]};
            W_H: w_result = {{48{~w_uns_n & w_raw[15]}}, w_raw[15:0]};
            W_W: w_result = {{32{~w_uns_n & w_raw[31]}}, w_raw[31:0]};
            W_D: w_result = w_raw;
            default: w_result = w_raw;
        endcase
    end

    always_comb begin
        w_valid_n = (w_state_n == ST_EMIT);
        w_busy_n  = (w_state_n != ST_IDLE);
        w_part_n  = r_part;
        w_data_n  = r_data;
        if (w_valid_n) begin
            w_part_n = w_idx_n;
            w_data_n = w_result[{w_idx_n, 4'b0000} +: 16];
        end
    end

    assign load_valid          = r_valid;
    assign load_part           = r_part;
    assign load_data           = r_data;
    assign load_busy           = r_busy;
    assign load_protocol_error = r_err;

endmodule

// File: tb/tb_clarvi_load_assembler.sv
// Directed bench for clarvi_load_assembler.
// Define LOAD_EARLY_EMIT_EN to exercise the early-emit path.
module tb_clarvi_load_assembler;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        main_read_pending = 1'b0;
    logic [1:0]  read_part = 2'd0;
    logic        word_offset = 1'b0;
    logic [1:0]  memory_width = 2'd0;
    logic        memory_read_unsigned = 1'b0;
    logic [15:0] main_read_data = 16'd0;
    logic        load_valid;
    logic [1:0]  load_part;
    logic [15:0] load_data;
    logic        load_busy;
    logic        load_protocol_error;

    int n_cmp = 0;
    int n_bad = 0;

    clarvi_load_assembler dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .stall               (stall),
        .flush               (flush),
        .main_read_pending   (main_read_pending),
        .read_part           (read_part),
        .word_offset         (word_offset),
        .memory_width        (memory_width),
        .memory_read_unsigned(memory_read_unsigned),
        .main_read_data      (main_read_data),
        .load_valid          (load_valid),
        .load_part           (load_part),
        .load_data           (load_data),
        .load_busy           (load_busy),
        .load_protocol_error (load_protocol_error)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic p, input logic [1:0] part,
                         input logic [15:0] d);
        main_read_pending = p;
        read_part = part;
        main_read_data = d;
    endtask

    task automatic setup(input logic [1:0] w, input logic off, input logic uns);
        memory_width = w;
        word_offset = off;
        memory_read_unsigned = uns;
    endtask

    task automatic feed4(input logic [63:0] hws);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[1:0], hws[16*i +: 16]);
            tick();
        end
        drive(1'b0, 2'd0, 16'd0);
    endtask

    task automatic test_reset;
        #12;
        n_cmp++;
        if ({load_valid, load_part, load_data, load_busy, load_protocol_error} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {load_valid, load_part, load_data, load_busy, load_protocol_error});
        end
        #1 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_ld;
        logic [15:0] exp_d [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        setup(2'd3, 1'b0, 1'b0);
        feed4(64'h4444_3333_2222_1111);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({load_valid, load_part, load_data} !== {1'b1, i[1:0], exp_d[i]}) begin
                n_bad++;
                $display("FAIL ld_part%0d: got v%b p%0d %h expected v1 p%0d %h",
                         i, load_valid, load_part, load_data, i, exp_d[i]);
            end
            tick();
        end
        n_cmp++;
        if ({load_valid, load_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL ld_idle: got v%b b%b expected v0 b0", load_valid, load_busy);
        end
    endtask

    task automatic test_lb(input logic uns);
        logic [15:0] exp_d [4];
        if (uns) exp_d = '{16'h0080, 16'h0000, 16'h0000, 16'h0000};
        else     exp_d = '{16'hFF80, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        setup(2'd0, 1'b1, uns);
        feed4(64'h7777_6666_5555_80AB);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({load_valid, load_part, load_data} !== {1'b1, i[1:0], exp_d[i]}) begin
                n_bad++;
                $display("FAIL lb_u%0b_part%0d: got v%b p%0d %h expected v1 p%0d %h",
                         uns, i, load_valid, load_part, load_data, i, exp_d[i]);
            end
            tick();
        end
    endtask

    task automatic test_lw_stall;
        logic [15:0] exp_d [6] = '{16'h1234, 16'h8765, 16'h8765, 16'h8765,
                                   16'hFFFF, 16'hFFFF};
        logic [1:0]  exp_p [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
        logic        st    [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        setup(2'd2, 1'b0, 1'b0);
        feed4(64'hBBBB_AAAA_8765_1234);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if ({load_valid, load_part, load_data} !== {1'b1, exp_p[k], exp_d[k]}) begin
                n_bad++;
                $display("FAIL lw_stall_cyc%0d: got v%b p%0d %h expected v1 p%0d %h",
                         k, load_valid, load_part, load_data, exp_p[k], exp_d[k]);
            end
            stall = st[k];
            tick();
        end
        stall = 1'b0;
        n_cmp++;
        if (load_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lw_end: got v%b expected v0", load_valid);
        end
    endtask

    task automatic test_lhu;
        logic [15:0] exp_d [4] = '{16'h8001, 16'h0000, 16'h0000, 16'h0000};
        setup(2'd1, 1'b0, 1'b1);
`ifdef LOAD_EARLY_EMIT_EN
        drive(1'b1, 2'd0, 16'h8001);
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({load_valid, load_part, load_data} !== {1'b1, i[1:0], exp_d[i]}) begin
                n_bad++;
                $display("FAIL early_part%0d: got v%b p%0d %h expected v1 p%0d %h",
                         i, load_valid, load_part, load_data, i, exp_d[i]);
            end
            if (i < 3) drive(1'b1, 2'(i + 1), 16'hC0DE);
            else drive(1'b0, 2'd0, 16'd0);
            tick();
        end
`else
        drive(1'b1, 2'd0, 16'h8001);
        tick();
        n_cmp++;
        if ({load_valid, load_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL lhu_wait: got v%b b%b expected v0 b1", load_valid, load_busy);
        end
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, i[1:0], 16'hC0DE);
            tick();
        end
        drive(1'b0, 2'd0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({load_valid, load_part, load_data} !== {1'b1, i[1:0], exp_d[i]}) begin
                n_bad++;
                $display("FAIL lhu_part%0d: got v%b p%0d %h expected v1 p%0d %h",
                         i, load_valid, load_part, load_data, i, exp_d[i]);
            end
            tick();
        end
`endif
        n_cmp++;
        if ({load_valid, load_protocol_error} !== 2'b00) begin
            n_bad++;
            $display("FAIL lhu_end: got v%b e%b expected v0 e0",
                     load_valid, load_protocol_error);
        end
    endtask

    task automatic test_protocol;
        logic seen_valid = 1'b0;
        setup(2'd3, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 16'hAAAA);
        tick();
        n_cmp++;
        if ({load_valid, load_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL proto_collect: got v%b b%b expected v0 b1", load_valid, load_busy);
        end
        drive(1'b1, 2'd2, 16'hBBBB);
        tick();
        drive(1'b0, 2'd0, 16'd0);
        n_cmp++;
        if ({load_protocol_error, load_busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL proto_err: got e%b b%b expected e1 b0",
                     load_protocol_error, load_busy);
        end
        for (int k = 0; k < 5; k++) begin
            seen_valid = seen_valid | load_valid;
            tick();
        end
        n_cmp++;
        if ({seen_valid, load_protocol_error} !== 2'b01) begin
            n_bad++;
            $display("FAIL proto_hold: got valid_seen %b e%b expected 0 and e1",
                     seen_valid, load_protocol_error);
        end
    endtask

    task automatic test_flush;
        logic [15:0] exp_d [4] = '{16'h2211, 16'h3322, 16'h4433, 16'h0044};
        setup(2'd3, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 16'h9999);
        tick();
        drive(1'b1, 2'd1, 16'h8888);
        tick();
        drive(1'b0, 2'd0, 16'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if ({load_valid, load_busy, load_protocol_error} !== 3'b001) begin
            n_bad++;
            $display("FAIL flush_idle: got v%b b%b e%b expected v0 b0 e1",
                     load_valid, load_busy, load_protocol_error);
        end
        setup(2'd3, 1'b1, 1'b0);
        feed4(64'h4444_3333_2222_1111);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({load_valid, load_part, load_data} !== {1'b1, i[1:0], exp_d[i]}) begin
                n_bad++;
                $display("FAIL ld_off1_part%0d: got v%b p%0d %h expected v1 p%0d %h",
                         i, load_valid, load_part, load_data, i, exp_d[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid;
        setup(2'd3, 1'b0, 1'b0);
        feed4(64'h4444_3333_2222_1111);
        tick();
        n_cmp++;
        if ({load_valid, load_part} !== 3'b101) begin
            n_bad++;
            $display("FAIL mid_emit: got v%b p%0d expected v1 p1", load_valid, load_part);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({load_valid, load_part, load_data, load_busy, load_protocol_error} !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got %h expected 0",
                     {load_valid, load_part, load_data, load_busy, load_protocol_error});
        end
        #2 reset_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({load_valid, load_busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_after: got v%b b%b expected v0 b0", load_valid, load_busy);
        end
    endtask

    initial begin
        test_reset();
        test_ld();
        test_lb(1'b0);
        test_lb(1'b1);
        test_lw_stall();
        test_lhu();
        test_protocol();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
